// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code decoder: pops bytes from the receive FIFO, resolves E0/F0 prefixes,
// tracks the held key and keeps a BCD press count.
module ps2_key_tracker #(
    parameter int COUNT_DIGITS = 2,
    parameter int REPEAT_COUNT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                data,
    input  logic                      ready,
    input  logic                      overflow,
    output logic                      nextdata_n,
    output logic                      key_held,
    output logic [7:0]                key_code,
    output logic                      key_ext,
    output logic                      press_pulse,
    output logic                      repeat_pulse,
    output logic                      release_pulse,
    output logic [4*COUNT_DIGITS-1:0] press_count,
    output logic                      count_wrap,
    output logic                      ovf_flag
);

    localparam int CW = 4 * COUNT_DIGITS;

    typedef enum logic [1:0] {HS_ACCEPT, HS_POP, HS_WAIT} hs_state_t;
    typedef enum logic [1:0] {PF_NORM, PF_EXT, PF_BRK, PF_EXTBRK} pf_state_t;

    hs_state_t hs_q, hs_d;
    pf_state_t pf_q, pf_d;

    logic          vld_p0;
    logic          is_code_p0;
    logic          ext_p0;
    logic          brk_p0;
    logic          match_p0;
    logic          new_press_p0;
    logic          repeat_p0;
    logic          release_p0;
    logic          inc_en_p0;
    logic [CW:0]   inc_res_p0;

    // Digit-wise BCD increment; bit CW is the carry out of the top digit.
    function automatic logic [CW:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < COUNT_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return {carry, r};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q <= HS_ACCEPT;
        end else begin
            hs_q <= hs_d;
        end
    end

    always_comb begin
        hs_d   = hs_q;
        vld_p0 = 1'b0;
        case (hs_q)
            HS_ACCEPT: begin
                if (ready) begin
                    vld_p0 = 1'b1;
                    hs_d   = HS_POP;
                end
            end
            HS_POP:  hs_d = HS_WAIT;
            HS_WAIT: hs_d = HS_ACCEPT;
            default: hs_d = HS_ACCEPT;
        endcase
    end

    // Prefix decoding: E0 always restarts an extended sequence, F0 marks a break.
    always_comb begin
        pf_d       = pf_q;
        is_code_p0 = 1'b0;
        ext_p0     = (pf_q == PF_EXT) || (pf_q == PF_EXTBRK);
        brk_p0     = (pf_q == PF_BRK) || (pf_q == PF_EXTBRK);
        if (vld_p0) begin
            if (data == 8'hE0) begin
                pf_d = PF_EXT;
            end else if (data == 8'hF0) begin
                case (pf_q)
                    PF_NORM: pf_d = PF_BRK;
                    PF_EXT:  pf_d = PF_EXTBRK;
                    default: pf_d = pf_q;
                endcase
            end else begin
                is_code_p0 = 1'b1;
                pf_d       = PF_NORM;
            end
        end
    end

    always_comb begin
        match_p0     = key_held && (ext_p0 == key_ext) && (data == key_code);
        new_press_p0 = is_code_p0 && !brk_p0 && !match_p0;
        repeat_p0    = is_code_p0 && !brk_p0 && match_p0;
        release_p0   = is_code_p0 && brk_p0 && match_p0;
        inc_en_p0    = new_press_p0 || (repeat_p0 && (REPEAT_COUNT != 0));
        inc_res_p0   = bcd_inc(press_count);
    end

    // Stage boundary: decoded events become registered outputs one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pf_q          <= PF_NORM;
            nextdata_n    <= 1'b1;
            key_held      <= 1'b0;
            key_code      <= 8'h00;
            key_ext       <= 1'b0;
            press_pulse   <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
            count_wrap    <= 1'b0;
            ovf_flag      <= 1'b0;
        end else begin
            pf_q          <= pf_d;
            nextdata_n    <= (hs_d != HS_POP);
            press_pulse   <= new_press_p0;
            repeat_pulse  <= repeat_p0;
            release_pulse <= release_p0;
            count_wrap    <= inc_en_p0 && inc_res_p0[CW];
            ovf_flag      <= ovf_flag || overflow;
            if (new_press_p0) begin
                key_held <= 1'b1;
                key_code <= data;
                key_ext  <= ext_p0;
            end else if (release_p0) begin
                key_held <= 1'b0;
            end
            if (inc_en_p0) begin
                press_count <= inc_res_p0[CW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: a FIFO model feeds bytes, a scan-code model predicts every output.
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       ready = 1'b0;
    logic       overflow = 1'b0;

    logic       nd0, held0, ext0, pp0, rp0, lp0, cw0, ovf0;
    logic [7:0] code0, cnt0_o;
    logic       nd1, held1, ext1, pp1, rp1, lp1, cw1, ovf1;
    logic [7:0] code1, cnt1_o;

    always #5 clk = ~clk;

    ps2_key_tracker #(.COUNT_DIGITS(2), .REPEAT_COUNT(0)) u0 (
        .clk(clk), .rst(rst), .data(data), .ready(ready), .overflow(overflow),
        .nextdata_n(nd0), .key_held(held0), .key_code(code0), .key_ext(ext0),
        .press_pulse(pp0), .repeat_pulse(rp0), .release_pulse(lp0),
        .press_count(cnt0_o), .count_wrap(cw0), .ovf_flag(ovf0)
    );

    ps2_key_tracker #(.COUNT_DIGITS(2), .REPEAT_COUNT(1)) u1 (
        .clk(clk), .rst(rst), .data(data), .ready(ready), .overflow(overflow),
        .nextdata_n(nd1), .key_held(held1), .key_code(code1), .key_ext(ext1),
        .press_pulse(pp1), .repeat_pulse(rp1), .release_pulse(lp1),
        .press_count(cnt1_o), .count_wrap(cw1), .ovf_flag(ovf1)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic       rst_s = 1'b1;
    logic       ovf_s = 1'b0;

    logic       m_held, m_ext, m_pext, m_pbrk, m_ovf;
    logic [7:0] m_code;
    logic       m_press, m_rep, m_rel, m_wrap0, m_wrap1;
    int         m_cnt0, m_cnt1;

    int n_press0 = 0, n_rep0 = 0, n_rel0 = 0, n_wrap0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Abstract scan-code semantics: prefixes accumulate, a code byte consumes them.
    task automatic model_byte(input logic [7:0] b);
        logic ext, brk, same;
        if (b == 8'hE0) begin
            m_pext = 1'b1;
            m_pbrk = 1'b0;
        end else if (b == 8'hF0) begin
            m_pbrk = 1'b1;
        end else begin
            ext    = m_pext;
            brk    = m_pbrk;
            m_pext = 1'b0;
            m_pbrk = 1'b0;
            same   = m_held && (ext == m_ext) && (b == m_code);
            if (!brk) begin
                if (same) begin
                    m_rep  = 1'b1;
                    m_cnt1 = m_cnt1 + 1;
                end else begin
                    m_press = 1'b1;
                    m_held  = 1'b1;
                    m_code  = b;
                    m_ext   = ext;
                    m_cnt0  = m_cnt0 + 1;
                    m_cnt1  = m_cnt1 + 1;
                end
                if (m_cnt0 == 100) begin m_cnt0 = 0; m_wrap0 = 1'b1; end
                if (m_cnt1 == 100) begin m_cnt1 = 0; m_wrap1 = 1'b1; end
            end else if (same) begin
                m_held = 1'b0;
                m_rel  = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        rst_s = rst;
        ovf_s = overflow;
    end

    always @(negedge clk) begin : mdl
        m_press = 1'b0; m_rep = 1'b0; m_rel = 1'b0; m_wrap0 = 1'b0; m_wrap1 = 1'b0;
        if (rst_s) begin
            m_held = 1'b0; m_ext = 1'b0; m_code = 8'h00; m_pext = 1'b0; m_pbrk = 1'b0;
            m_ovf = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
            chk("rst_nextdata_n_u0", 32'(nd0), 32'd1);
            chk("rst_nextdata_n_u1", 32'(nd1), 32'd1);
        end else begin
            if (ovf_s) m_ovf = 1'b1;
            if (nd0 === 1'b0) begin
                if (q.size() == 0) chk("pop_nonempty", 32'd0, 32'd1);
                else model_byte(q.pop_front());
            end
        end
        chk("key_held_u0", 32'(held0), 32'(m_held));
        chk("key_code_u0", 32'(code0), 32'(m_code));
        chk("key_ext_u0", 32'(ext0), 32'(m_ext));
        chk("press_pulse_u0", 32'(pp0), 32'(m_press));
        chk("repeat_pulse_u0", 32'(rp0), 32'(m_rep));
        chk("release_pulse_u0", 32'(lp0), 32'(m_rel));
        chk("press_count_u0", 32'(cnt0_o), 32'(to_bcd(m_cnt0)));
        chk("count_wrap_u0", 32'(cw0), 32'(m_wrap0));
        chk("ovf_flag_u0", 32'(ovf0), 32'(m_ovf));
        chk("key_held_u1", 32'(held1), 32'(m_held));
        chk("key_code_u1", 32'(code1), 32'(m_code));
        chk("key_ext_u1", 32'(ext1), 32'(m_ext));
        chk("press_pulse_u1", 32'(pp1), 32'(m_press));
        chk("repeat_pulse_u1", 32'(rp1), 32'(m_rep));
        chk("release_pulse_u1", 32'(lp1), 32'(m_rel));
        chk("press_count_u1", 32'(cnt1_o), 32'(to_bcd(m_cnt1)));
        chk("count_wrap_u1", 32'(cw1), 32'(m_wrap1));
        chk("ovf_flag_u1", 32'(ovf1), 32'(m_ovf));
        if (pp0 === 1'b1) n_press0++;
        if (rp0 === 1'b1) n_rep0++;
        if (lp0 === 1'b1) n_rel0++;
        if (cw0 === 1'b1) n_wrap0++;
        ready = (q.size() != 0);
        data  = (q.size() != 0) ? q[0] : 8'h00;
    end

    task automatic push(input logic [7:0] b);
        q.push_back(b);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stim
        int bp, br, bl, bw, t;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Plain make/break
        bp = n_press0; bl = n_rel0;
        push(8'h1C); push(8'hF0); push(8'h1C);
        drain();
        chk("mb_press_n", 32'(n_press0 - bp), 32'd1);
        chk("mb_release_n", 32'(n_rel0 - bl), 32'd1);
        chk("mb_code", 32'(code0), 32'h1C);
        chk("mb_held", 32'(held0), 32'd0);
        chk("mb_count", 32'(cnt0_o), 32'h01);

        // Extended key, then an unprefixed break that must not release it
        do_reset();
        bl = n_rel0;
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        drain();
        chk("ext_ext", 32'(ext0), 32'd1);
        chk("ext_code", 32'(code0), 32'h75);
        chk("ext_count", 32'(cnt0_o), 32'h01);
        chk("ext_release_n", 32'(n_rel0 - bl), 32'd1);
        push(8'hE0); push(8'h75);
        drain();
        bl = n_rel0;
        push(8'hF0); push(8'h75);
        drain();
        chk("mismatch_release_n", 32'(n_rel0 - bl), 32'd0);
        chk("mismatch_held", 32'(held0), 32'd1);

        // Typematic repeats
        do_reset();
        bp = n_press0; br = n_rep0; bl = n_rel0;
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        drain();
        chk("typ_press_n", 32'(n_press0 - bp), 32'd1);
        chk("typ_repeat_n", 32'(n_rep0 - br), 32'd2);
        chk("typ_release_n", 32'(n_rel0 - bl), 32'd1);
        chk("typ_count_rc0", 32'(cnt0_o), 32'h01);
        chk("typ_count_rc1", 32'(cnt1_o), 32'h03);

        // BCD wrap after 100 presses
        do_reset();
        bw = n_wrap0;
        for (int i = 0; i < 99; i++) begin
            push(8'h2B); push(8'hF0); push(8'h2B);
        end
        drain();
        chk("wrap_count_99", 32'(cnt0_o), 32'h99);
        chk("wrap_none_yet", 32'(n_wrap0 - bw), 32'd0);
        push(8'h2B); push(8'hF0); push(8'h2B);
        drain();
        chk("wrap_count_00", 32'(cnt0_o), 32'h00);
        chk("wrap_pulse_n", 32'(n_wrap0 - bw), 32'd1);

        // Reset discards a partial E0 F0 prefix
        do_reset();
        push(8'hE0); push(8'hF0);
        drain();
        do_reset();
        bp = n_press0;
        push(8'h1C);
        drain();
        chk("rstseq_press_n", 32'(n_press0 - bp), 32'd1);
        chk("rstseq_ext", 32'(ext0), 32'd0);
        chk("rstseq_code", 32'(code0), 32'h1C);

        // Back-to-back handshake with an overflow pulse
        do_reset();
        for (int i = 0; i < 12; i++) push(8'h29);
        t = 0;
        while (nd0 !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("hs_first_pop", 32'(nd0), 32'd0);
        overflow = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            overflow = 1'b0;
            chk("hs_pop_pattern", 32'(nd0), (k % 3 == 0) ? 32'd0 : 32'd1);
        end
        drain();
        chk("ovf_set", 32'(ovf0), 32'd1);
        repeat (5) @(negedge clk);
        chk("ovf_sticky", 32'(ovf1), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(ovf0), 32'd0);
        chk("rst_count", 32'(cnt1_o), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
